// File: rtl/arp_pkg.sv
// ARP field constants and byte layout shared by the ARP receive-side blocks.
// Offsets are byte indices from the first byte of the Ethernet destination MAC.
package arp_pkg;

    localparam logic [15:0] ETH_TYPE_ARP = 16'h0806;
    localparam logic [15:0] HRD_ETH      = 16'h0001;
    localparam logic [15:0] PRO_IPV4     = 16'h0800;
    localparam logic [7:0]  HLN_ETH      = 8'h06;
    localparam logic [7:0]  PLN_IPV4     = 8'h04;
    localparam logic [15:0] OP_REQUEST   = 16'h0001;
    localparam logic [15:0] OP_REPLY     = 16'h0002;

    localparam int ARP_FRAME_LEN = 42;
    localparam int MAC_BYTES     = 6;
    localparam int IPV4_BYTES    = 4;

    localparam logic [5:0] OFF_DST  = 6'd0;
    localparam logic [5:0] OFF_SRC  = 6'd6;
    localparam logic [5:0] OFF_TYPE = 6'd12;
    localparam logic [5:0] OFF_HRD  = 6'd14;
    localparam logic [5:0] OFF_PRO  = 6'd16;
    localparam logic [5:0] OFF_HLN  = 6'd18;
    localparam logic [5:0] OFF_PLN  = 6'd19;
    localparam logic [5:0] OFF_OP   = 6'd20;
    localparam logic [5:0] OFF_SHA  = 6'd22;
    localparam logic [5:0] OFF_SPA  = 6'd28;
    localparam logic [5:0] OFF_THA  = 6'd32;
    localparam logic [5:0] OFF_TPA  = 6'd38;
    localparam logic [5:0] OFF_LAST = 6'd41;

    typedef enum logic [1:0] {P_IDLE, P_PARSE, P_DROP} parse_state_t;
    typedef enum logic       {L_IDLE, L_PEND}          lookup_state_t;

    // k counts from the most significant byte, matching wire order
    function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [5:0] k);
        return mac[47 - 8 * int'(k) -: 8];
    endfunction

    function automatic logic [7:0] ip_byte(input logic [31:0] ip, input logic [5:0] k);
        return ip[31 - 8 * int'(k) -: 8];
    endfunction

endpackage

// File: rtl/arp_lookup_timer.sv
// Pending-lookup tracker: latches the target IP, times the lookup out, and
// turns an accepted reply into the RESOLVED result (resolution beats timeout).
//   state  | meaning
//   L_IDLE | no lookup outstanding, a start request is accepted
//   L_PEND | lookup outstanding, counting toward timeout
module arp_lookup_timer
#(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int CNT_W          = 20
) (
    input  logic        CLK_RX,
    input  logic        ARESET,
    input  logic        lookup_start,
    input  logic [31:0] lookup_ipv4,
    input  logic        accept,
    input  logic [47:0] shadow_mac,
    output logic        busy,
    output logic [31:0] target_ipv4,
    output logic        resolved,
    output logic [47:0] resolved_mac,
    output logic [31:0] resolved_ipv4,
    output logic        timeout
);
    import arp_pkg::*;

    // counter is 0 in the first busy cycle; the pulse is registered one edge later
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 2);

    lookup_state_t    state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic             take, fire_res, fire_to;

    always_comb begin
        state_nx = state;
        take     = 1'b0;
        fire_res = 1'b0;
        fire_to  = 1'b0;
        case (state)
            L_IDLE: begin
                if (lookup_start) begin
                    take     = 1'b1;
                    state_nx = L_PEND;
                end
            end
            L_PEND: begin
                if (accept) begin
                    fire_res = 1'b1;
                    state_nx = L_IDLE;
                end else if (cnt == CNT_LAST) begin
                    fire_to  = 1'b1;
                    state_nx = L_IDLE;
                end
            end
            default: state_nx = L_IDLE;
        endcase
    end

    always_ff @(posedge CLK_RX) begin
        if (ARESET) begin
            state         <= L_IDLE;
            cnt           <= '0;
            target_ipv4   <= '0;
            resolved      <= 1'b0;
            timeout       <= 1'b0;
            resolved_mac  <= '0;
            resolved_ipv4 <= '0;
        end else begin
            state    <= state_nx;
            resolved <= fire_res;
            timeout  <= fire_to;
            if (take) begin
                target_ipv4 <= lookup_ipv4;
                cnt         <= '0;
            end else if (state == L_PEND) begin
                cnt <= cnt + 1'b1;
            end
            if (fire_res) begin
                resolved_mac  <= shadow_mac;
                resolved_ipv4 <= target_ipv4;
            end
        end
    end

    assign busy = (state == L_PEND);

endmodule

// File: rtl/arp_reply_rx.sv
// ARP reply receiver: parses the RX byte stream for a reply answering the
// pending lookup and hands acceptance to the lookup timer.
//   state   | meaning
//   P_IDLE  | between frames, waiting for a DATA_VALID_RX rising edge
//   P_PARSE | checking bytes 1..41 of a candidate reply
//   P_DROP  | frame rejected or finished, waiting for DATA_VALID_RX low
module arp_reply_rx
    import arp_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int CNT_W          = 20
) (
    input  logic        CLK_RX,
    input  logic        ARESET,
    input  logic [47:0] MY_MAC,
    input  logic [31:0] MY_IPV4,
    input  logic        DATA_VALID_RX,
    input  logic [7:0]  DATA_RX,
    input  logic        LOOKUP_START,
    input  logic [31:0] LOOKUP_IPV4,
    output logic        LOOKUP_BUSY,
    output logic        RESOLVED,
    output logic [47:0] RESOLVED_MAC,
    output logic [31:0] RESOLVED_IPV4,
    output logic        TIMEOUT
);

    parse_state_t pst, pst_nx;
    logic         dv_d;
    logic [5:0]   idx, cur_idx;
    logic         eligible, frame_start, accept;
    logic [47:0]  sha;
    logic [31:0]  target_ipv4;
    logic [7:0]   exp_byte;
    logic         check_byte, byte_ok;

    assign frame_start = DATA_VALID_RX & ~dv_d;
    assign cur_idx     = (pst == P_PARSE) ? idx : OFF_DST;

    always_comb begin
        exp_byte   = '0;
        check_byte = 1'b1;
        if (cur_idx < OFF_SRC) begin
            exp_byte = mac_byte(MY_MAC, cur_idx - OFF_DST);
        end else if (cur_idx < OFF_TYPE) begin
            check_byte = 1'b0;
        end else if (cur_idx < OFF_SHA) begin
            case (cur_idx)
                OFF_TYPE:        exp_byte = ETH_TYPE_ARP[15:8];
                OFF_TYPE + 6'd1: exp_byte = ETH_TYPE_ARP[7:0];
                OFF_HRD:         exp_byte = HRD_ETH[15:8];
                OFF_HRD + 6'd1:  exp_byte = HRD_ETH[7:0];
                OFF_PRO:         exp_byte = PRO_IPV4[15:8];
                OFF_PRO + 6'd1:  exp_byte = PRO_IPV4[7:0];
                OFF_HLN:         exp_byte = HLN_ETH;
                OFF_PLN:         exp_byte = PLN_IPV4;
                OFF_OP:          exp_byte = OP_REPLY[15:8];
                OFF_OP + 6'd1:   exp_byte = OP_REPLY[7:0];
                default:         check_byte = 1'b0;
            endcase
        end else if (cur_idx < OFF_SPA) begin
            check_byte = 1'b0;
        end else if (cur_idx < OFF_THA) begin
            exp_byte = ip_byte(target_ipv4, cur_idx - OFF_SPA);
        end else if (cur_idx < OFF_TPA) begin
            exp_byte = mac_byte(MY_MAC, cur_idx - OFF_THA);
        end else begin
            exp_byte = ip_byte(MY_IPV4, cur_idx - OFF_TPA);
        end
    end

    assign byte_ok = ~check_byte | (DATA_RX == exp_byte);

    always_comb begin
        pst_nx = pst;
        accept = 1'b0;
        case (pst)
            P_IDLE: begin
                if (frame_start) pst_nx = byte_ok ? P_PARSE : P_DROP;
            end
            P_PARSE: begin
                if (!DATA_VALID_RX) begin
                    pst_nx = P_IDLE;
                end else if (!byte_ok || idx == OFF_LAST) begin
                    pst_nx = P_DROP;
                    accept = byte_ok & (idx == OFF_LAST) & eligible;
                end
            end
            P_DROP: begin
                if (!DATA_VALID_RX) pst_nx = P_IDLE;
            end
            default: pst_nx = P_IDLE;
        endcase
    end

    // dv_d resets high so a frame already in flight at reset release is skipped
    always_ff @(posedge CLK_RX) begin
        if (ARESET) begin
            pst      <= P_IDLE;
            dv_d     <= 1'b1;
            idx      <= '0;
            eligible <= 1'b0;
            sha      <= '0;
        end else begin
            pst  <= pst_nx;
            dv_d <= DATA_VALID_RX;
            idx  <= (pst == P_PARSE) ? idx + 6'd1 : 6'd1;
            if (pst == P_IDLE && frame_start) begin
                eligible <= LOOKUP_BUSY;
                sha      <= '0;
            end else if (pst == P_PARSE && DATA_VALID_RX && idx >= OFF_SHA && idx < OFF_SPA) begin
                sha <= {sha[39:0], DATA_RX};
            end
        end
    end

    arp_lookup_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_timer (
        .CLK_RX        (CLK_RX),
        .ARESET        (ARESET),
        .lookup_start  (LOOKUP_START),
        .lookup_ipv4   (LOOKUP_IPV4),
        .accept        (accept),
        .shadow_mac    (sha),
        .busy          (LOOKUP_BUSY),
        .target_ipv4   (target_ipv4),
        .resolved      (RESOLVED),
        .resolved_mac  (RESOLVED_MAC),
        .resolved_ipv4 (RESOLVED_IPV4),
        .timeout       (TIMEOUT)
    );

endmodule

// File: tb/tb_arp_reply_rx.sv
// Bench for arp_reply_rx: frame table, hand-timed corner sequences and random
// traffic, all compared every cycle against a frame-level reference model.
module tb_arp_reply_rx;

    localparam int TO = 100;
    localparam logic [47:0] MY_MAC_C  = 48'h02AABBCCDDEE;
    localparam logic [31:0] MY_IPV4_C = 32'hC0A80164;
    localparam logic [31:0] IP_A = 32'hC0A8010A;
    localparam logic [31:0] IP_B = 32'hC0A80101;

    logic        CLK_RX = 1'b0;
    logic        ARESET = 1'b1;
    logic [47:0] MY_MAC = MY_MAC_C;
    logic [31:0] MY_IPV4 = MY_IPV4_C;
    logic        DATA_VALID_RX = 1'b0;
    logic [7:0]  DATA_RX = 8'h00;
    logic        LOOKUP_START = 1'b0;
    logic [31:0] LOOKUP_IPV4 = 32'h0;
    logic        LOOKUP_BUSY, RESOLVED, TIMEOUT;
    logic [47:0] RESOLVED_MAC;
    logic [31:0] RESOLVED_IPV4;

    arp_reply_rx #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
        .CLK_RX(CLK_RX), .ARESET(ARESET), .MY_MAC(MY_MAC), .MY_IPV4(MY_IPV4),
        .DATA_VALID_RX(DATA_VALID_RX), .DATA_RX(DATA_RX),
        .LOOKUP_START(LOOKUP_START), .LOOKUP_IPV4(LOOKUP_IPV4),
        .LOOKUP_BUSY(LOOKUP_BUSY), .RESOLVED(RESOLVED), .RESOLVED_MAC(RESOLVED_MAC),
        .RESOLVED_IPV4(RESOLVED_IPV4), .TIMEOUT(TIMEOUT)
    );

    always #5 CLK_RX = ~CLK_RX;

    int n_cmp = 0, n_err = 0, cyc = 0;
    int n_res_seen = 0, n_to_seen = 0;
    logic [7:0] frame_q[$];
    logic [31:0] ips[3];

    // reference model state: lookup by absolute deadline, frames as byte lists
    bit          m_busy, m_res, m_to, m_dvp = 1'b1, m_coll, m_elig;
    logic [47:0] m_mac;
    logic [31:0] m_ip, m_target;
    int          m_deadline;
    logic [7:0]  m_buf[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit frame_ok();
        logic [7:0] e[42];
        bit         care[42];
        logic [7:0] hdr[10];
        logic [47:0] t;
        hdr = '{8'h08, 8'h06, 8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h02};
        for (int i = 0; i < 42; i++) begin e[i] = 8'h00; care[i] = 1'b1; end
        for (int i = 0; i < 6; i++) begin
            t = MY_MAC_C >> (8 * (5 - i));
            e[i] = t[7:0];
            e[32 + i] = t[7:0];
            care[6 + i] = 1'b0;
            care[22 + i] = 1'b0;
        end
        for (int i = 0; i < 10; i++) e[12 + i] = hdr[i];
        for (int i = 0; i < 4; i++) begin
            t = 48'(m_target) >> (8 * (3 - i));
            e[28 + i] = t[7:0];
            t = 48'(MY_IPV4_C) >> (8 * (3 - i));
            e[38 + i] = t[7:0];
        end
        for (int i = 0; i < 42; i++)
            if (care[i] && m_buf[i] !== e[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_step();
        bit acc;
        acc = 1'b0;
        if (ARESET) begin
            m_busy = 0; m_res = 0; m_to = 0; m_mac = '0; m_ip = '0; m_target = '0;
            m_dvp = 1'b1; m_coll = 1'b0; m_elig = 1'b0;
            return;
        end
        if (DATA_VALID_RX && !m_dvp) begin
            m_coll = 1'b1;
            m_buf.delete();
            m_elig = m_busy;
        end
        if (m_coll) begin
            if (!DATA_VALID_RX) m_coll = 1'b0;
            else begin
                m_buf.push_back(DATA_RX);
                if (m_buf.size() == 42) begin
                    m_coll = 1'b0;
                    acc = frame_ok() && m_elig;
                end
            end
        end
        m_res = 1'b0;
        m_to = 1'b0;
        if (m_busy) begin
            if (acc) begin
                m_res = 1'b1; m_busy = 1'b0; m_ip = m_target;
                m_mac = {m_buf[22], m_buf[23], m_buf[24], m_buf[25], m_buf[26], m_buf[27]};
            end else if (cyc == m_deadline) begin
                m_to = 1'b1; m_busy = 1'b0;
            end
        end else if (LOOKUP_START) begin
            m_busy = 1'b1; m_target = LOOKUP_IPV4; m_deadline = cyc + TO - 1;
        end
        m_dvp = DATA_VALID_RX;
    endtask

    task automatic tick();
        @(posedge CLK_RX);
        cyc++;
        model_step();
        #1;
        chk("busy", 64'(LOOKUP_BUSY), 64'(m_busy));
        chk("resolved", 64'(RESOLVED), 64'(m_res));
        chk("timeout", 64'(TIMEOUT), 64'(m_to));
        chk("res_mac", 64'(RESOLVED_MAC), 64'(m_mac));
        chk("res_ip", 64'(RESOLVED_IPV4), 64'(m_ip));
        if (RESOLVED) n_res_seen++;
        if (TIMEOUT) n_to_seen++;
    endtask

    task automatic push_n(input logic [47:0] v, input int n);
        logic [47:0] t;
        for (int i = n - 1; i >= 0; i--) begin
            t = v >> (8 * i);
            frame_q.push_back(t[7:0]);
        end
    endtask

    task automatic build_frame(input logic [47:0] dst, input logic [15:0] op,
                               input logic [47:0] sha, input logic [31:0] spa, input int len);
        frame_q.delete();
        push_n(dst, 6);
        push_n(48'({$urandom(), $urandom()}), 6);
        push_n(48'h0806, 2); push_n(48'h0001, 2); push_n(48'h0800, 2);
        push_n(48'h06, 1); push_n(48'h04, 1); push_n(48'(op), 2);
        push_n(sha, 6); push_n(48'(spa), 4); push_n(MY_MAC_C, 6); push_n(48'(MY_IPV4_C), 4);
        while (frame_q.size() < len) frame_q.push_back(8'h00);
        while (frame_q.size() > len) void'(frame_q.pop_back());
    endtask

    task automatic send_frame(input bit rnd);
        for (int i = 0; i < frame_q.size(); i++) begin
            DATA_VALID_RX = 1'b1;
            DATA_RX = frame_q[i];
            if (rnd) begin
                LOOKUP_START = ($urandom_range(0, 15) == 0);
                LOOKUP_IPV4 = ips[$urandom_range(0, 2)];
            end
            tick();
        end
        LOOKUP_START = 1'b0;
        DATA_VALID_RX = 1'b0;
        DATA_RX = 8'h00;
        tick();
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 3 * TO && LOOKUP_BUSY; i++) tick();
        chk("wait_idle", 64'(LOOKUP_BUSY), 64'd0);
    endtask

    task automatic start_lookup(input logic [31:0] ip);
        LOOKUP_START = 1'b1;
        LOOKUP_IPV4 = ip;
        tick();
        LOOKUP_START = 1'b0;
    endtask

    typedef struct {
        logic [31:0] ip;
        logic [47:0] dst;
        logic [15:0] op;
        logic [31:0] spa;
        int          corrupt;
        int          len;
        logic [47:0] sha;
        bit          exp_res;
        logic [47:0] exp_mac;
    } vec_t;

    initial begin
        vec_t tbl[10];
        int r0, t0, c0, tcyc, kind, len;
        logic [47:0] rs;

        ips[0] = IP_A; ips[1] = IP_B; ips[2] = 32'h0A000001;
        tbl[0] = '{IP_A, MY_MAC_C, 16'h0002, IP_A, -1, 42, 48'h021122334455, 1'b1, 48'h021122334455};
        tbl[1] = '{IP_A, MY_MAC_C, 16'h0001, IP_A, -1, 42, 48'h021122334455, 1'b0, 48'h0};
        tbl[2] = '{IP_A, MY_MAC_C, 16'h0002, 32'hC0A8010B, -1, 42, 48'h021122334455, 1'b0, 48'h0};
        tbl[3] = '{IP_A, 48'hFFFFFFFFFFFF, 16'h0002, IP_A, -1, 42, 48'h021122334455, 1'b0, 48'h0};
        tbl[4] = '{IP_A, MY_MAC_C, 16'h0002, IP_A, 12, 42, 48'h021122334455, 1'b0, 48'h0};
        tbl[5] = '{IP_A, MY_MAC_C, 16'h0002, IP_A, 19, 42, 48'h021122334455, 1'b0, 48'h0};
        tbl[6] = '{IP_B, MY_MAC_C, 16'h0002, IP_B, 34, 42, 48'h021122334455, 1'b0, 48'h0};
        tbl[7] = '{IP_B, MY_MAC_C, 16'h0002, IP_B, 40, 42, 48'h021122334455, 1'b0, 48'h0};
        tbl[8] = '{IP_B, MY_MAC_C, 16'h0002, IP_B, 8, 42, 48'h0A0B0C0D0E0F, 1'b1, 48'h0A0B0C0D0E0F};
        tbl[9] = '{IP_A, MY_MAC_C, 16'h0002, IP_A, 24, 60, 48'h021122334455, 1'b1, 48'h0211DD334455};

        // reset state
        repeat (3) tick();
        chk("rst_busy", 64'(LOOKUP_BUSY), 64'd0);
        chk("rst_mac", 64'(RESOLVED_MAC), 64'd0);
        ARESET = 1'b0;
        tick();

        foreach (tbl[k]) begin
            wait_idle();
            start_lookup(tbl[k].ip);
            r0 = n_res_seen;
            build_frame(tbl[k].dst, tbl[k].op, tbl[k].sha, tbl[k].spa, tbl[k].len);
            if (tbl[k].corrupt >= 0) frame_q[tbl[k].corrupt] = frame_q[tbl[k].corrupt] ^ 8'hFF;
            send_frame(1'b0);
            chk($sformatf("tbl%0d_res", k), 64'(n_res_seen - r0), 64'(tbl[k].exp_res));
            chk($sformatf("tbl%0d_busy", k), 64'(LOOKUP_BUSY), 64'(!tbl[k].exp_res));
            if (tbl[k].exp_res) begin
                chk($sformatf("tbl%0d_mac", k), 64'(RESOLVED_MAC), 64'(tbl[k].exp_mac));
                chk($sformatf("tbl%0d_ip", k), 64'(RESOLVED_IPV4), 64'(tbl[k].ip));
            end
        end

        // timeout with no reply, then a late reply is ignored
        wait_idle();
        start_lookup(IP_A);
        c0 = cyc; tcyc = -1;
        for (int i = 0; i < 2 * TO; i++) begin
            tick();
            if (TIMEOUT) begin tcyc = cyc; break; end
        end
        chk("to_cycle", 64'(tcyc - c0 + 1), 64'(TO));
        chk("to_busy", 64'(LOOKUP_BUSY), 64'd0);
        r0 = n_res_seen;
        build_frame(MY_MAC_C, 16'h0002, 48'h021122334455, IP_A, 42);
        send_frame(1'b0);
        chk("late_reply", 64'(n_res_seen - r0), 64'd0);

        // truncated reply then a padded one
        start_lookup(IP_B);
        r0 = n_res_seen;
        build_frame(MY_MAC_C, 16'h0002, 48'h0A0B0C0D0E0F, IP_B, 30);
        send_frame(1'b0);
        chk("trunc_res", 64'(n_res_seen - r0), 64'd0);
        build_frame(MY_MAC_C, 16'h0002, 48'h060504030201, IP_B, 60);
        send_frame(1'b0);
        chk("pad_res", 64'(n_res_seen - r0), 64'd1);
        chk("pad_mac", 64'(RESOLVED_MAC), 64'h060504030201);

        // acceptance on the timeout cycle; a start while busy is ignored
        wait_idle();
        start_lookup(IP_A);
        c0 = cyc; r0 = n_res_seen; t0 = n_to_seen;
        build_frame(MY_MAC_C, 16'h0002, 48'h0A1B2C3D4E5F, IP_A, 42);
        while (cyc < c0 + 57) begin
            LOOKUP_START = (cyc == c0 + 20);
            LOOKUP_IPV4 = 32'h01020304;
            tick();
        end
        LOOKUP_START = 1'b0;
        send_frame(1'b0);
        chk("race_res", 64'(n_res_seen - r0), 64'd1);
        chk("race_to", 64'(n_to_seen - t0), 64'd0);
        chk("race_ip", 64'(RESOLVED_IPV4), 64'(IP_A));
        chk("race_mac", 64'(RESOLVED_MAC), 64'h0A1B2C3D4E5F);

        // reset mid-frame, released while the frame continues
        start_lookup(IP_B);
        r0 = n_res_seen;
        build_frame(MY_MAC_C, 16'h0002, 48'h112233445566, IP_B, 42);
        for (int i = 0; i < 42; i++) begin
            DATA_VALID_RX = 1'b1;
            DATA_RX = frame_q[i];
            ARESET = (i == 25 || i == 26);
            tick();
            if (i == 26) begin
                chk("mid_rst_busy", 64'(LOOKUP_BUSY), 64'd0);
                chk("mid_rst_mac", 64'(RESOLVED_MAC), 64'd0);
                chk("mid_rst_ip", 64'(RESOLVED_IPV4), 64'd0);
            end
        end
        DATA_VALID_RX = 1'b0;
        tick();
        chk("mid_rst_res", 64'(n_res_seen - r0), 64'd0);
        start_lookup(IP_B);
        send_frame(1'b0);
        chk("post_rst_res", 64'(n_res_seen - r0), 64'd1);
        chk("post_rst_mac", 64'(RESOLVED_MAC), 64'h112233445566);

        // random traffic against the model
        for (int it = 0; it < 250; it++) begin
            kind = $urandom_range(0, 3);
            if (kind == 0) begin
                repeat ($urandom_range(1, 20)) begin
                    LOOKUP_START = ($urandom_range(0, 3) == 0);
                    LOOKUP_IPV4 = ips[$urandom_range(0, 2)];
                    tick();
                end
                LOOKUP_START = 1'b0;
            end else begin
                rs = 48'({$urandom(), $urandom()});
                len = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 41) : $urandom_range(42, 60);
                build_frame(($urandom_range(0, 7) == 0) ? 48'hFFFFFFFFFFFF : MY_MAC_C,
                            ($urandom_range(0, 7) == 0) ? 16'h0001 : 16'h0002,
                            rs, ips[$urandom_range(0, 2)], len);
                if ($urandom_range(0, 3) == 0) begin
                    kind = $urandom_range(0, len - 1);
                    frame_q[kind] = frame_q[kind] ^ 8'h5A;
                end
                send_frame(1'b1);
                repeat ($urandom_range(0, 2)) tick();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #10000000;
        $display("FAIL watchdog: run did not finish, got cycle %0d expected completion", cyc);
        $fatal(1);
    end

endmodule
